exec_controller: RTL and testbench
==================================

EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter MAX_CYCLES, default 16'hFFFF: watchdog limit, in enabled core cycles, per run.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 iStart  input  1  level-sampled start/resume request.
REQ-005 iStep  input  1  single-step request.
REQ-006 iHalt  input  1  stop request.
REQ-007 iIP  input  16  current instruction pointer from the datapath.
REQ-008 iBreakAddr  input  16  breakpoint instruction address.
REQ-009 oCoreEnable  output  1  datapath clock enable; IP advances and register writes occur only when high.
REQ-010 oCoreReset  output  1  one-cycle synchronous reset pulse to the datapath (IP to 0).
REQ-011 oState  output  3  encoded state: IDLE=0, RSTCORE=1, RUN=2, STEP=3, BREAK=4, TIMEOUT=5.
REQ-012 oInstrCount  output  16  number of enabled core cycles since the last core reset.
REQ-013 oTimeout  output  1  high while in TIMEOUT.

Function
REQ-014 Request priority within a cycle: iHalt > iStart > iStep.
REQ-015 IDLE: oCoreEnable=0. iStart -> RSTCORE. iStep -> STEP.
REQ-016 RSTCORE lasts exactly 1 cycle: oCoreReset=1, oCoreEnable=0, oInstrCount cleared to 0, then -> RUN.
REQ-017 RUN: oCoreEnable=1 unless the REQ-019 breakpoint condition holds. iHalt -> BREAK, and oCoreEnable is 0 in the cycle iHalt is sampled.
REQ-018 STEP lasts exactly 1 cycle: oCoreEnable=1, then -> state of origin (IDLE or BREAK). Breakpoint and iHalt are ignored in STEP.
REQ-019 Breakpoint: in RUN, when iIP==iBreakAddr, oCoreEnable is combinationally 0 that cycle (instruction at iBreakAddr is not executed), then -> BREAK.
REQ-020 The first RUN cycle after leaving BREAK ignores breakpoint match, so resuming at iBreakAddr does not re-break.
REQ-021 BREAK: oCoreEnable=0. iStart -> RUN without core reset, counter retained. iStep -> STEP.
REQ-022 oInstrCount increments by 1 on every cycle with oCoreEnable=1 and saturates at 16'hFFFF.
REQ-023 Watchdog: in RUN, when oInstrCount==MAX_CYCLES at a clock edge -> TIMEOUT, and oCoreEnable=0 in that cycle. iHalt in the same cycle -> BREAK (priority to halt).
REQ-024 TIMEOUT: oCoreEnable=0, oTimeout=1. iStart -> RSTCORE. iStep ignored.
REQ-025 Requests are not queued: a request not acted on in its sampled state is dropped.
REQ-026 iStart held high in RUN has no effect. A level held across a return to IDLE re-triggers.

Reset
REQ-027 Asserting Reset (low) at any time, including mid-RUN or mid-STEP, immediately forces state=IDLE, oCoreEnable=0, oCoreReset=0, oInstrCount=0, oTimeout=0.
REQ-028 After deassertion the block stays in IDLE until a request arrives.
REQ-029 Reset does not itself pulse oCoreReset. The datapath is reset separately.

Configuration
REQ-030 Macro EXEC_BREAKPOINT_EN: when defined, REQ-019/REQ-020 are implemented.
REQ-031 When EXEC_BREAKPOINT_EN is not defined: iBreakAddr is ignored, no compare logic is built, and BREAK is entered only via iHalt. All other behaviour is unchanged.

Verification
REQ-032 Reset low mid-RUN with oInstrCount=37 -> same cycle: oState=0, oCoreEnable=0, oInstrCount=0.
REQ-033 iStart pulse in IDLE -> oCoreReset high for exactly 1 cycle with oState=1, then oState=2 and oCoreEnable=1. After 10 RUN cycles oInstrCount=10.
REQ-034 (EXEC_BREAKPOINT_EN) iBreakAddr=16'h0005, IP increments from 0 -> oCoreEnable=0 when iIP=5, oState=4, oInstrCount=5. iStart -> RUN, IP 5 executes, no re-break.
REQ-035 In BREAK with oInstrCount=5, iStep 1-cycle pulse -> exactly one enabled cycle, oInstrCount=6, return to oState=4.
REQ-036 MAX_CYCLES=8, iStart -> after 8 enabled cycles oState=5, oTimeout=1, oCoreEnable=0. iStep ignored. iStart -> RSTCORE, count=0.
REQ-037 iHalt and iStart asserted together in RUN -> BREAK, and oCoreEnable=0 in that cycle.

Source files
------------

// File: rtl/exec_controller_if.sv
`default_nettype none
// ============================================================================
//  exec_controller_if
//  Request/status bundle between a run controller and its datapath/host.
//  Revision: 1.0
// ============================================================================
interface exec_controller_if;
  logic        iStart;
  logic        iStep;
  logic        iHalt;
  logic [15:0] iIP;
  logic [15:0] iBreakAddr;
  logic        oCoreEnable;
  logic        oCoreReset;
  logic [2:0]  oState;
  logic [15:0] oInstrCount;
  logic        oTimeout;

  modport master (
    output iStart, iStep, iHalt, iIP, iBreakAddr,
    input  oCoreEnable, oCoreReset, oState, oInstrCount, oTimeout
  );

  modport slave (
    input  iStart, iStep, iHalt, iIP, iBreakAddr,
    output oCoreEnable, oCoreReset, oState, oInstrCount, oTimeout
  );
endinterface
`default_nettype wire

// File: rtl/exec_controller.sv
`default_nettype none
// ============================================================================
//  exec_controller
//  Run/step/break/watchdog controller gating a datapath clock enable.
//  Optional feature: define EXEC_BREAKPOINT_EN to build the IP breakpoint.
//  Revision: 1.0
// ============================================================================
module exec_controller #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  exec_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSTCORE = 3'd1,
    RUN     = 3'd2,
    STEP    = 3'd3,
    BREAK   = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_coreEnable;
  logic        w_coreReset;
  logic        w_bpHit;
  logic        r_stepFromBreak;
  logic [15:0] r_instrCount;

`ifdef EXEC_BREAKPOINT_EN
  // Set only for the first RUN cycle after BREAK so a resume at the
  // breakpoint address executes that instruction instead of re-breaking.
  logic r_resumed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resumed <= 1'b0;
    end else begin
      r_resumed <= (r_state == BREAK) && (w_nextState == RUN);
    end
  end

  assign w_bpHit = (bus.iIP == bus.iBreakAddr) && !r_resumed;
`else
  wire w_unusedBp = ^{bus.iIP, bus.iBreakAddr};
  assign w_bpHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_coreEnable = 1'b0;
    w_coreReset  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.iHalt) begin
          if (bus.iStart)     w_nextState = RSTCORE;
          else if (bus.iStep) w_nextState = STEP;
        end
      end
      RSTCORE: begin
        w_coreReset = 1'b1;
        w_nextState = RUN;
      end
      RUN: begin
        // >= rather than == so a count pushed past the limit by stepping
        // still trips the watchdog on the next RUN cycle.
        if (bus.iHalt || w_bpHit)          w_nextState = BREAK;
        else if (r_instrCount >= MAX_CYCLES) w_nextState = TIMEOUT;
        else                               w_coreEnable = 1'b1;
      end
      STEP: begin
        w_coreEnable = 1'b1;
        w_nextState  = r_stepFromBreak ? BREAK : IDLE;
      end
      BREAK: begin
        if (!bus.iHalt) begin
          if (bus.iStart)     w_nextState = RUN;
          else if (bus.iStep) w_nextState = STEP;
        end
      end
      TIMEOUT: begin
        if (!bus.iHalt && bus.iStart) w_nextState = RSTCORE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stepFromBreak <= 1'b0;
    end else if (w_nextState == STEP) begin
      r_stepFromBreak <= (r_state == BREAK);
    end
  end

  // Cleared on entry to RSTCORE so the count already reads 0 during the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrCount <= 16'd0;
    end else if (w_nextState == RSTCORE) begin
      r_instrCount <= 16'd0;
    end else if (w_coreEnable && (r_instrCount != 16'hFFFF)) begin
      r_instrCount <= r_instrCount + 16'd1;
    end
  end

  assign bus.oCoreEnable = w_coreEnable;
  assign bus.oCoreReset  = w_coreReset;
  assign bus.oState      = r_state;
  assign bus.oInstrCount = r_instrCount;
  assign bus.oTimeout    = (r_state == TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_exec_controller.sv
`default_nettype none
// ============================================================================
//  tb_exec_controller
//  Scoreboard bench for exec_controller with a simple incrementing-IP datapath.
//  Revision: 1.0
// ============================================================================
module tb_exec_controller;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RSTCORE = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_STEP    = 3'd3;
  localparam logic [2:0] S_BREAK   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_controller_if bus();

  exec_controller #(.MAX_CYCLES(16'd40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath model: IP advances on enabled cycles, zeroed by the core reset.
  logic [15:0] ip;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ip <= 16'd0;
    else if (bus.oCoreReset)  ip <= 16'd0;
    else if (bus.oCoreEnable) ip <= ip + 16'd1;
  end
  assign bus.iIP = ip;

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic        cr;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   numChecks = 0;
  int   numFails  = 0;
  int   cycNum    = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycNum, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkValue("state",      {29'd0, bus.oState},      {29'd0, monE.st});
      checkValue("coreEnable", {31'd0, bus.oCoreEnable}, {31'd0, monE.en});
      checkValue("coreReset",  {31'd0, bus.oCoreReset},  {31'd0, monE.cr});
      checkValue("instrCount", {16'd0, bus.oInstrCount}, {16'd0, monE.cnt});
      checkValue("timeout",    {31'd0, bus.oTimeout},    {31'd0, monE.to});
    end
  end

  // One clock: drive requests just after the edge, queue what the outputs must be.
  task automatic cyc(input logic s, input logic st, input logic h,
                     input logic [2:0] es, input logic een, input logic ecr,
                     input logic [15:0] ecnt, input logic eto);
    @(posedge clk);
    #1;
    bus.iStart = s;
    bus.iStep  = st;
    bus.iHalt  = h;
    cycNum++;
    expQ.push_back('{st: es, en: een, cr: ecr, cnt: ecnt, to: eto});
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.iStart = 1'b0;
    bus.iStep  = 1'b0;
    bus.iHalt  = 1'b0;
    #1;
    checkValue("rst_state", {29'd0, bus.oState}, 32'd0);
    checkValue("rst_enable", {31'd0, bus.oCoreEnable}, 32'd0);
    checkValue("rst_count", {16'd0, bus.oInstrCount}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Start from IDLE: start sampled, one RSTCORE cycle, then RUN with n enabled cycles.
  task automatic startAndRun(input int n, input logic [15:0] idleCnt);
    cyc(1, 0, 0, S_IDLE, 0, 0, idleCnt, 0);
    cyc(0, 0, 0, S_RSTCORE, 0, 1, 16'd0, 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, S_RUN, 1, 0, 16'(i), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.iStart     = 1'b0;
    bus.iStep      = 1'b0;
    bus.iHalt      = 1'b0;
    bus.iBreakAddr = 16'hFFF0;
    #12;
    checkValue("por_state",     {29'd0, bus.oState},      32'd0);
    checkValue("por_enable",    {31'd0, bus.oCoreEnable}, 32'd0);
    checkValue("por_coreReset", {31'd0, bus.oCoreReset},  32'd0);
    checkValue("por_count",     {16'd0, bus.oInstrCount}, 32'd0);
    checkValue("por_timeout",   {31'd0, bus.oTimeout},    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle stays idle; start -> RSTCORE -> RUN; held start in RUN is harmless.
    cyc(0, 0, 0, S_IDLE, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, S_IDLE, 0, 0, 16'd0, 0);
    cyc(1, 0, 0, S_IDLE, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, S_RSTCORE, 0, 1, 16'd0, 0);
    for (int i = 0; i < 37; i++)
      cyc((i >= 20 && i < 23), 0, 0, S_RUN, 1, 0, 16'(i), 0);

    // Asynchronous reset in the middle of RUN at count 37.
    @(posedge clk);
    #1;
    checkValue("pre_rst_count", {16'd0, bus.oInstrCount}, 32'd37);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async_state",     {29'd0, bus.oState},      32'd0);
    checkValue("async_enable",    {31'd0, bus.oCoreEnable}, 32'd0);
    checkValue("async_count",     {16'd0, bus.oInstrCount}, 32'd0);
    checkValue("async_coreReset", {31'd0, bus.oCoreReset},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single step from IDLE returns to IDLE.
    cyc(0, 0, 0, S_IDLE, 0, 0, 16'd0, 0);
    cyc(0, 1, 0, S_IDLE, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, S_STEP, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, S_IDLE, 0, 0, 16'd1, 0);

    // Halt+start together in RUN -> BREAK; step from BREAK; resume keeps count.
    startAndRun(5, 16'd1);
    cyc(1, 0, 1, S_RUN, 0, 0, 16'd5, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd5, 0);
    cyc(0, 1, 0, S_BREAK, 0, 0, 16'd5, 0);
    cyc(0, 0, 0, S_STEP, 1, 0, 16'd5, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd6, 0);
    cyc(1, 0, 0, S_BREAK, 0, 0, 16'd6, 0);
    cyc(0, 0, 0, S_RUN, 1, 0, 16'd6, 0);
    cyc(0, 0, 0, S_RUN, 1, 0, 16'd7, 0);
    cyc(0, 0, 1, S_RUN, 0, 0, 16'd8, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd8, 0);
    doReset();

    // Breakpoint at IP 5.
    bus.iBreakAddr = 16'h0005;
    startAndRun(5, 16'd0);
`ifdef EXEC_BREAKPOINT_EN
    cyc(0, 0, 0, S_RUN, 0, 0, 16'd5, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd5, 0);
    cyc(1, 0, 0, S_BREAK, 0, 0, 16'd5, 0);
    cyc(0, 0, 0, S_RUN, 1, 0, 16'd5, 0);
    cyc(0, 0, 0, S_RUN, 1, 0, 16'd6, 0);
    cyc(0, 0, 1, S_RUN, 0, 0, 16'd7, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd7, 0);
`else
    for (int i = 5; i < 8; i++) cyc(0, 0, 0, S_RUN, 1, 0, 16'(i), 0);
    cyc(0, 0, 1, S_RUN, 0, 0, 16'd8, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd8, 0);
`endif
    bus.iBreakAddr = 16'hFFF0;
    doReset();

    // Watchdog at 40 enabled cycles; step ignored; start restarts via RSTCORE.
    startAndRun(40, 16'd0);
    cyc(0, 0, 0, S_RUN, 0, 0, 16'd40, 0);
    cyc(0, 1, 0, S_TIMEOUT, 0, 0, 16'd40, 1);
    cyc(0, 0, 0, S_TIMEOUT, 0, 0, 16'd40, 1);
    cyc(1, 0, 0, S_TIMEOUT, 0, 0, 16'd40, 1);
    cyc(0, 0, 0, S_RSTCORE, 0, 1, 16'd0, 0);
    cyc(0, 0, 0, S_RUN, 1, 0, 16'd0, 0);
    cyc(0, 0, 1, S_RUN, 0, 0, 16'd1, 0);
    cyc(0, 0, 0, S_BREAK, 0, 0, 16'd1, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      numChecks++;
      numFails++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
`default_nettype wire
